// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder and subtractor).
//   sa_state_e   : IDLE / SHIFT / DONE control states
//   SA_WIDTH     : default operand width
//   sa_cnt_width : bit-counter width for a given operand width
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_e;

  localparam int unsigned SA_WIDTH = 8;

  // Counter must reach WIDTH-1; guard keeps at least one bit for tiny widths.
  function automatic int unsigned sa_cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: captures a and b on start, computes a - b LSB-first
// through a single borrow flop, then presents diff/borrow_out with a done pulse.
//   clk, reset  : clock, synchronous active-high reset
//   start       : request, sampled only in IDLE
//   a, b        : minuend / subtrahend, captured on the accepted start edge
//   busy        : high in SHIFT and DONE
//   done        : one-cycle pulse when diff/borrow_out are fresh
//   diff        : a - b modulo 2^WIDTH
//   borrow_out  : unsigned underflow (a < b)
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = sa_cnt_width(WIDTH);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_d, done_d, borrow_d;
  logic [WIDTH-1:0] diff_d;

  logic d_bit;
  logic bout_bit;
  logic last_bit;

  // Single shared bit slice; operands are presented at bit 0 of the shift regs.
  full_subtractor_bit u_fsb (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff;
    borrow_d = borrow_out;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          r_d     = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {d_bit, r_q[WIDTH-1:1]};
        br_d  = bout_bit;
        cnt_d = cnt_q + CW'(1);
        // Publish only on the final bit so partial results never show.
        if (last_bit) begin
          diff_d   = {d_bit, r_q[WIDTH-1:1]};
          borrow_d = bout_bit;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags registered from the upcoming state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      br_q       <= br_d;
      cnt_q      <= cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      diff       <= diff_d;
      borrow_out <= borrow_d;
    end
  end

endmodule
